// File: rtl/softmax_pkg.sv
// Shared state encoding and default latencies for the softmax sequencer.
package softmax_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, RECIP, NORM} state_t;

  localparam int DEF_TOTAL_WORDS     = 16;
  localparam int DEF_PARALLEL_FACTOR = 32;
  localparam int DEF_EXP_LAT         = 8;
  localparam int DEF_TREE_LAT        = 15;
  localparam int DEF_ACC_LAT         = 4;
  localparam int DEF_RECIP_LAT       = 10;
  localparam int DEF_MULT_LAT        = 5;

  function automatic int addr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sm_valid_delay.sv
// Fixed-depth shift line carrying a valid bit and its beat address, cleared by rst.
module sm_valid_delay #(
  parameter int DEPTH  = 1,
  parameter int ADDR_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_d,
  input  logic [ADDR_W-1:0] addr_d,
  output logic              vld_q,
  output logic [ADDR_W-1:0] addr_q
);

  logic [DEPTH-1:0]  vld_p;
  logic [ADDR_W-1:0] addr_p [DEPTH];

  // Addresses are cleared too so every framing output reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
      for (int i = 0; i < DEPTH; i++) addr_p[i] <= '0;
    end else begin
      vld_p[0]  <= vld_d;
      addr_p[0] <= addr_d;
      for (int i = 1; i < DEPTH; i++) begin
        vld_p[i]  <= vld_p[i-1];
        addr_p[i] <= addr_p[i-1];
      end
    end
  end

  assign vld_q  = vld_p[DEPTH-1];
  assign addr_q = addr_p[DEPTH-1];

endmodule

// File: rtl/softmax_seq_ctrl.sv
// Three-phase sequencer (load/accumulate, reciprocal, normalise) for the softmax datapath.
// Define SOFTMAX_PERF_CNT_EN to add the perf_cycles start-to-done counter output.
module softmax_seq_ctrl
  import softmax_pkg::*;
#(
  parameter int TOTAL_WORDS     = DEF_TOTAL_WORDS,
  parameter int PARALLEL_FACTOR = DEF_PARALLEL_FACTOR,
  parameter int EXP_LAT         = DEF_EXP_LAT,
  parameter int TREE_LAT        = DEF_TREE_LAT,
  parameter int ACC_LAT         = DEF_ACC_LAT,
  parameter int RECIP_LAT       = DEF_RECIP_LAT,
  parameter int MULT_LAT        = DEF_MULT_LAT,
  parameter int ADDR_W          = addr_width(TOTAL_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              acc_en,
  output logic              acc_n,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic              reci_valid,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef SOFTMAX_PERF_CNT_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  if (TOTAL_WORDS < 1 || PARALLEL_FACTOR < 1) begin : g_bad_cfg
    $error("softmax_seq_ctrl: TOTAL_WORDS and PARALLEL_FACTOR must be >= 1");
  end

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL_WORDS - 1);
  // DRAIN spans from the cycle after the last accept up to the cycle the acc1 sum is stable.
  localparam logic [15:0] DRAIN_END = 16'(EXP_LAT + TREE_LAT + ACC_LAT - 2);
  localparam logic [15:0] RECIP_END = 16'(RECIP_LAT - 1);

  state_t            state;
  logic [ADDR_W-1:0] beats;
  logic [15:0]       phase_cnt;
  logic              accept;
  logic [ADDR_W-1:0] acc_addr;
  logic [ADDR_W-1:0] out_addr;

  assign in_ready = (state == LOAD);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      beats       <= '0;
      phase_cnt   <= '0;
      reci_valid  <= 1'b0;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state       <= LOAD;
          beats       <= '0;
          ram_rd_addr <= '0;
        end
        LOAD: if (accept) begin
          if (beats == LAST_ADDR) begin
            state     <= DRAIN;
            phase_cnt <= '0;
          end else begin
            beats <= beats + 1'b1;
          end
        end
        DRAIN: if (phase_cnt == DRAIN_END) begin
          state     <= RECIP;
          phase_cnt <= '0;
        end else begin
          phase_cnt <= phase_cnt + 1'b1;
        end
        RECIP: if (phase_cnt == RECIP_END) begin
          state       <= NORM;
          reci_valid  <= 1'b1;
          ram_rd_en   <= 1'b1;
          ram_rd_addr <= '0;
        end else begin
          phase_cnt <= phase_cnt + 1'b1;
        end
        NORM: begin
          if (ram_rd_en) begin
            if (ram_rd_addr == LAST_ADDR) ram_rd_en <= 1'b0;
            else ram_rd_addr <= ram_rd_addr + 1'b1;
          end
          if (out_last) begin
            state      <= IDLE;
            reci_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // accept -> expo -> exponent-buffer write
  sm_valid_delay #(.DEPTH(EXP_LAT), .ADDR_W(ADDR_W)) u_wr_dly (
    .clk(clk), .rst(rst), .vld_d(accept), .addr_d(beats),
    .vld_q(ram_wr_en), .addr_q(ram_wr_addr)
  );

  // expo output -> adder tree -> acc1 enable
  sm_valid_delay #(.DEPTH(TREE_LAT), .ADDR_W(ADDR_W)) u_acc_dly (
    .clk(clk), .rst(rst), .vld_d(ram_wr_en), .addr_d(ram_wr_addr),
    .vld_q(acc_en), .addr_q(acc_addr)
  );

  // buffer read (1 cycle) -> multiplier1 -> output beat
  sm_valid_delay #(.DEPTH(1 + MULT_LAT), .ADDR_W(ADDR_W)) u_out_dly (
    .clk(clk), .rst(rst), .vld_d(ram_rd_en), .addr_d(ram_rd_addr),
    .vld_q(out_valid), .addr_q(out_addr)
  );

  assign acc_n    = acc_en && (acc_addr == '0);
  assign out_last = out_valid && (out_addr == LAST_ADDR);
  assign done     = out_last;

`ifdef SOFTMAX_PERF_CNT_EN
  logic [31:0] perf_cnt;

  // Counts 1 on the first busy cycle, so the value seen at done equals cycles since start.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt    <= '0;
      perf_cycles <= '0;
    end else begin
      if (state == IDLE && start) perf_cnt <= 32'd1;
      else if (state != IDLE && perf_cnt != 32'hFFFF_FFFF) perf_cnt <= perf_cnt + 32'd1;
      if (done) perf_cycles <= perf_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Directed bench for softmax_seq_ctrl with a timestamped scoreboard of write, acc and output events.
module tb_softmax_seq_ctrl;

  localparam int TW = 16, EXP_LAT = 8, TREE_LAT = 15, ACC_LAT = 4, RECIP_LAT = 10, MULT_LAT = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic in_ready, acc_en, acc_n, ram_wr_en, ram_rd_en, reci_valid, out_valid, out_last, busy, done;
  logic [3:0] ram_wr_addr, ram_rd_addr;
  logic start1 = 1'b0, in_valid1 = 1'b0;
  logic in_ready1, acc_en1, acc_n1, ram_wr_en1, ram_rd_en1, reci_valid1, out_valid1, out_last1, busy1, done1;
  logic [0:0] ram_wr_addr1, ram_rd_addr1;
`ifdef SOFTMAX_PERF_CNT_EN
  logic [31:0] perf_cycles, perf_cycles1;
`endif

  softmax_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .acc_en(acc_en), .acc_n(acc_n), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .reci_valid(reci_valid),
    .out_valid(out_valid), .out_last(out_last), .busy(busy), .done(done)
`ifdef SOFTMAX_PERF_CNT_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  softmax_seq_ctrl #(.TOTAL_WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
    .acc_en(acc_en1), .acc_n(acc_n1), .ram_wr_en(ram_wr_en1), .ram_wr_addr(ram_wr_addr1),
    .ram_rd_en(ram_rd_en1), .ram_rd_addr(ram_rd_addr1), .reci_valid(reci_valid1),
    .out_valid(out_valid1), .out_last(out_last1), .busy(busy1), .done(done1)
`ifdef SOFTMAX_PERF_CNT_EN
    , .perf_cycles(perf_cycles1)
`endif
  );

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  typedef struct {int t; int v;} ev_t;
  ev_t wr_q[$], acc_q[$], out_q[$];
  int n_acc, n_wr, n_acc_en, n_accn, n_rd, n_out, first_acc, last_acc, first_rd, last_acc_en;

  task automatic reset_mon();
    wr_q.delete(); acc_q.delete(); out_q.delete();
    n_acc = 0; n_wr = 0; n_acc_en = 0; n_accn = 0; n_rd = 0; n_out = 0;
    first_acc = 0; last_acc = 0; first_rd = 0; last_acc_en = 0;
  endtask

  // Scoreboard: expectations are pushed when a beat is accepted or read, popped when the DUT emits.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (in_valid && in_ready) begin
        chk("accept_cnt_le_tw", int'(n_acc < TW), 1);
        if (n_acc == 0) first_acc = cyc;
        last_acc = cyc;
        wr_q.push_back('{cyc + EXP_LAT, n_acc});
        acc_q.push_back('{cyc + EXP_LAT + TREE_LAT, int'(n_acc == 0)});
        n_acc++;
      end
      if (ram_wr_en) begin
        chk("wr_expected", int'(wr_q.size() > 0), 1);
        if (wr_q.size() > 0) begin
          e = wr_q.pop_front();
          chk("wr_time", cyc, e.t);
          chk("wr_addr", int'(ram_wr_addr), e.v);
        end
        n_wr++;
      end
      if (acc_en) begin
        chk("acc_expected", int'(acc_q.size() > 0), 1);
        if (acc_q.size() > 0) begin
          e = acc_q.pop_front();
          chk("acc_time", cyc, e.t);
          chk("acc_n", int'(acc_n), e.v);
        end
        last_acc_en = cyc;
        n_acc_en++;
      end
      if (acc_n) n_accn++;
      if (ram_rd_en) begin
        chk("rd_addr", int'(ram_rd_addr), n_rd);
        chk("reci_valid_in_norm", int'(reci_valid), 1);
        if (n_rd == 0) first_rd = cyc;
        out_q.push_back('{cyc + 1 + MULT_LAT, int'(n_rd == TW - 1)});
        n_rd++;
      end
      if (out_valid) begin
        chk("out_expected", int'(out_q.size() > 0), 1);
        if (out_q.size() > 0) begin
          e = out_q.pop_front();
          chk("out_time", cyc, e.t);
          chk("out_last", int'(out_last), e.v);
          chk("done", int'(done), e.v);
        end
        n_out++;
      end
      if (done) chk("done_with_out_valid", int'(out_valid), 1);
    end
  end

  task automatic run_vec(input int toggle, input int start_in_norm);
    int s_cyc, d_cyc, got;
    reset_mon();
    start = 1'b1; s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < (toggle ? 40 : 20); i++) begin
      in_valid = toggle ? (i % 2 == 0) : 1'b1;
      start = (toggle && i == 3);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; start = 1'b0;
    chk("accepts", n_acc, TW);
    chk("accept_span", last_acc - first_acc, toggle ? 30 : 15);
    chk("busy_in_vector", int'(busy), 1);
    if (start_in_norm) begin
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(posedge clk); #1;
        got = int'(ram_rd_en);
      end
      chk("reached_norm", got, 1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = int'(done);
    end
    chk("done_seen", got, 1);
    d_cyc = cyc;
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    chk("reci_valid_after_done", int'(reci_valid), 0);
    chk("n_wr", n_wr, TW);
    chk("n_acc_en", n_acc_en, TW);
    chk("n_acc_n", n_accn, 1);
    chk("n_rd", n_rd, TW);
    chk("n_out", n_out, TW);
    chk("queues_empty", wr_q.size() + acc_q.size() + out_q.size(), 0);
    chk("recip_gap", first_rd - last_acc_en, ACC_LAT + RECIP_LAT);
`ifdef SOFTMAX_PERF_CNT_EN
    chk("perf_cycles", int'(perf_cycles), d_cyc - s_cyc);
`endif
  endtask

  initial begin
    int got, a1, e1, o1;
    reset_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_outputs", int'({acc_en, acc_n, ram_wr_en, ram_rd_en, reci_valid, out_valid, out_last, done}), 0);
    chk("rst_addrs", int'({ram_wr_addr, ram_rd_addr}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_vec(0, 1);
    run_vec(1, 0);

    // Abort mid-NORM, then a fresh vector must run cleanly.
    reset_mon();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      got = int'(ram_rd_en && ram_rd_addr == 4'd7);
    end
    chk("reached_rd_addr7", got, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_outputs", int'({acc_en, acc_n, ram_wr_en, ram_rd_en, reci_valid, out_valid, out_last, done, busy, in_ready}), 0);
    chk("abort_rd_addr", int'(ram_rd_addr), 0);
    @(posedge clk); #1;
    run_vec(0, 0);

    // Single-beat vector on the TOTAL_WORDS=1 instance.
    a1 = 0; e1 = 0; o1 = 0; got = 0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; in_valid1 = 1'b1;
    for (int i = 0; i < 150 && !got; i++) begin
      @(negedge clk);
      if (in_valid1 && in_ready1) a1++;
      if (acc_en1) begin e1++; chk("tw1_acc_n", int'(acc_n1), 1); end
      if (out_valid1) begin
        o1++;
        chk("tw1_out_last", int'(out_last1), 1);
        chk("tw1_done", int'(done1), 1);
        chk("tw1_rd_addr_seen", int'(ram_rd_addr1), 0);
      end
      got = int'(done1);
    end
    in_valid1 = 1'b0;
    chk("tw1_done_seen", got, 1);
    chk("tw1_accepts", a1, 1);
    chk("tw1_acc_en", e1, 1);
    chk("tw1_out_valid", o1, 1);
    @(negedge clk);
    chk("tw1_busy_after", int'(busy1), 0);
    chk("tw1_idle_outputs", int'({reci_valid1, ram_wr_en1, ram_rd_en1, ram_wr_addr1}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
